fifo_sync_param: RTL
====================

# fifo_sync_param

Parametrised single-clock FIFO, the next generation of the team's BRAM-backed synchronous FIFO. It adds configurable width and depth, an occupancy count, programmable almost-full and almost-empty flags, and overflow/underflow error pulses. An optional first-word-fall-through (FWFT) read port is selected at compile time. It sits between any producer and consumer in the same clock domain; storage is an inferred simple-dual-port RAM.

## Interface
- WIDTH, 16, data word width in bits
- DEPTH, 32, capacity in words; power of two, ≥ 4
- AF_LEVEL, DEPTH-2, ALMOST_FULL asserts when COUNT ≥ AF_LEVEL
- AE_LEVEL, 2, ALMOST_EMPTY asserts when COUNT ≤ AE_LEVEL
- CLK  in  1  clock; all logic on its rising edge
- RESET  in  1  synchronous, active-high reset
- DATA_WR  in  WIDTH  write data
- WR  in  1  write request
- RD  in  1  read request (FWFT: read acknowledge)
- DATA_RD  out  WIDTH  read data
- FULL  out  1  COUNT == DEPTH
- EMPTY  out  1  no word available to reader
- ALMOST_FULL  out  1  COUNT ≥ AF_LEVEL
- ALMOST_EMPTY  out  1  COUNT ≤ AE_LEVEL
- COUNT  out  $clog2(DEPTH)+1  words held, including any FWFT output-register word
- OVERFLOW  out  1  one-cycle pulse: WR while FULL
- UNDERFLOW  out  1  one-cycle pulse: RD while EMPTY

## Operation
- Pointers are ADDR_W+1 bits wide, where ADDR_W = $clog2(DEPTH). The low ADDR_W bits address the RAM; the MSB is the wrap bit. Pointers wrap naturally at 2·DEPTH.
- Write accepted: WR && !FULL. Read accepted: RD && !EMPTY. Rejected requests change no state except the error pulse.
- COUNT update, by accepted operations: +1 for write only, -1 for read only, unchanged for both or neither.
- Simultaneous WR and RD:
  - When FULL: the read is accepted, the write is rejected, OVERFLOW pulses, and COUNT becomes DEPTH-1.
  - When EMPTY (non-FWFT): the write is accepted, the read is rejected, UNDERFLOW pulses, and COUNT becomes 1.
  - Otherwise both are accepted.
- All flags decode from the registered COUNT (or the FWFT valid bit), so there are no combinational paths from WR or RD to the flags.
- OVERFLOW and UNDERFLOW are registered pulses, asserted on the edge after the offending request.
- RESET values: pointers 0, COUNT 0, EMPTY 1, FULL 0, ALMOST_EMPTY 1, ALMOST_FULL 0, OVERFLOW 0, UNDERFLOW 0, DATA_RD 0, FWFT valid 0.
- RESET asserted mid-operation discards the contents. The RAM is not cleared, and any request in the reset cycle is ignored.

## Timing
- Standard mode: DATA_RD updates on the edge after an accepted read (1-cycle latency) and holds between reads.
- Flags and COUNT reflect an operation on the same edge that performs it.
- FWFT mode: DATA_RD always presents the head word while EMPTY = 0. RD acts as an acknowledge that pops the word on that edge; the next word appears on DATA_RD the same edge.
- FWFT prefetch: an output register backed by a 1-cycle RAM read.
- FWFT bypass: if the output register is empty (or being vacated) and the RAM holds nothing, an accepted write loads the output register directly. EMPTY therefore falls one edge after a write into an empty FIFO.
- Back-to-back reads at one per cycle are sustained in both modes. Write throughput is one per cycle until FULL.

## Configuration
- FIFO_SYNC_FWFT_EN defined: FWFT read port as described above. UNDERFLOW fires only on RD while the output register is invalid.
- FIFO_SYNC_FWFT_EN undefined: standard registered read port with 1-cycle read latency. No output-register state is counted in COUNT.

## Structure
- Package fifo_sync_pkg holds:
  - the default WIDTH/DEPTH constants
  - a function computing the pointer and count widths from DEPTH
- Sub-module fifo_sync_ram: simple dual-port RAM, one write port and one read port with 1-cycle registered read, WIDTH × DEPTH, inferable as block RAM.

## Test plan
- Reset, then write 0x0001..0x0020 at DEPTH=32 -> FULL=1, COUNT=32, ALMOST_FULL high from COUNT=30, no OVERFLOW.
- One more WR at FULL with DATA_WR=0xDEAD -> OVERFLOW pulses 1 cycle, COUNT stays 32, 0xDEAD is never read out.
- Read all 32 words -> data 0x0001..0x0020 in order across the pointer wrap; EMPTY=1 after the 32nd read; an extra RD pulses UNDERFLOW.
- Simultaneous WR/RD at COUNT=5 for 10 cycles -> COUNT stays 5 and data order is preserved; at FULL, only the read is accepted.
- FWFT build: single write of 0x00AB into an empty FIFO -> EMPTY=0 and DATA_RD=0x00AB on the next edge without RD; RD then gives EMPTY=1 and COUNT=0.
- RESET asserted at COUNT=17 with WR high -> the next cycle shows COUNT=0, EMPTY=1, all pulses 0, and the write is ignored.

Source files
------------

// File: rtl/fifo_sync_pkg.sv
// fifo_sync_pkg
// Shared constants and helpers for the fifo_sync_param slice.
//   DEFAULT_WIDTH / DEFAULT_DEPTH : default data width and capacity
//   ptr_cnt_w(depth)              : width of the read/write pointers and of
//                                   COUNT; both need $clog2(depth)+1 bits
//                                   (pointer wrap bit / count of DEPTH).
package fifo_sync_pkg;

  localparam int DEFAULT_WIDTH = 16;
  localparam int DEFAULT_DEPTH = 32;

  function automatic int ptr_cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/fifo_sync_param_if.sv
// fifo_sync_param_if
// Handshake/data bundle between a producer/consumer and fifo_sync_param.
//   DATA_WR, WR, RD            : driven by the master (user side)
//   DATA_RD, FULL, EMPTY,
//   ALMOST_FULL, ALMOST_EMPTY,
//   COUNT, OVERFLOW, UNDERFLOW : driven by the slave (the FIFO)
interface fifo_sync_param_if
  import fifo_sync_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int DEPTH = DEFAULT_DEPTH
);

  localparam int CNT_W = ptr_cnt_w(DEPTH);

  logic [WIDTH-1:0] DATA_WR;
  logic             WR;
  logic             RD;
  logic [WIDTH-1:0] DATA_RD;
  logic             FULL;
  logic             EMPTY;
  logic             ALMOST_FULL;
  logic             ALMOST_EMPTY;
  logic [CNT_W-1:0] COUNT;
  logic             OVERFLOW;
  logic             UNDERFLOW;

  modport master (
    output DATA_WR, WR, RD,
    input  DATA_RD, FULL, EMPTY, ALMOST_FULL, ALMOST_EMPTY, COUNT,
           OVERFLOW, UNDERFLOW
  );

  modport slave (
    input  DATA_WR, WR, RD,
    output DATA_RD, FULL, EMPTY, ALMOST_FULL, ALMOST_EMPTY, COUNT,
           OVERFLOW, UNDERFLOW
  );

endinterface

// File: rtl/fifo_sync_ram.sv
// fifo_sync_ram
// Simple dual-port RAM, WIDTH x DEPTH, one write port and one read port with
// a registered (1-cycle) read. The read register has a synchronous reset so
// the FIFO output reads 0 after reset; the array itself is never cleared.
//   clk    : clock
//   srst   : synchronous reset of the read data register
//   we     : write enable,  waddr/wdata : write address/data
//   re     : read enable,   raddr       : read address
//   rdata  : registered read data, held while re is low
module fifo_sync_ram
  import fifo_sync_pkg::*;
#(
  parameter int WIDTH  = DEFAULT_WIDTH,
  parameter int DEPTH  = DEFAULT_DEPTH,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              srst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [WIDTH-1:0]  rdata
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] rdata_reg;

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      rdata_reg <= '0;
    end else if (re) begin
      rdata_reg <= mem[raddr];
    end
  end

  assign rdata = rdata_reg;

endmodule

// File: rtl/fifo_sync_param.sv
// fifo_sync_param
// Parametrised single-clock FIFO on an inferred simple-dual-port RAM, with
// occupancy count, programmable almost-full/almost-empty flags and registered
// overflow/underflow pulses.
//   CLK   : clock, all logic on its rising edge
//   RESET : synchronous active-high reset
//   bus   : fifo_sync_param_if.slave (DATA_WR/WR/RD in; DATA_RD, flags,
//           COUNT, OVERFLOW, UNDERFLOW out)
// Compile-time option: define FIFO_SYNC_FWFT_EN for a first-word-fall-through
// read port (RD becomes an acknowledge); undefined gives a registered read
// port with 1-cycle latency.
module fifo_sync_param
  import fifo_sync_pkg::*;
#(
  parameter int WIDTH    = DEFAULT_WIDTH,
  parameter int DEPTH    = DEFAULT_DEPTH,
  parameter int AF_LEVEL = DEPTH - 2,
  parameter int AE_LEVEL = 2
) (
  input logic            CLK,
  input logic            RESET,
  fifo_sync_param_if.slave bus
);

  localparam int ADDR_W = $clog2(DEPTH);
  localparam int PTR_W  = ptr_cnt_w(DEPTH);
  localparam int CNT_W  = ptr_cnt_w(DEPTH);

  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [CNT_W-1:0] count_reg;
  logic             overflow_reg;
  logic             underflow_reg;

  logic             full;
  logic             empty;
  logic             wr_acc;
  logic             rd_acc;
  logic             ram_we;
  logic             ram_re;
  logic [WIDTH-1:0] ram_q;

  assign full   = (count_reg == CNT_W'(DEPTH));
  assign wr_acc = bus.WR && !full;
  assign rd_acc = bus.RD && !empty;

`ifdef FIFO_SYNC_FWFT_EN
  // The RAM read register doubles as the output register for words that
  // came through the RAM; a separate bypass register catches a write that
  // lands while nothing is queued behind the head. byp_sel_reg picks which
  // of the two currently holds the head word.
  logic             out_valid_reg;
  logic             byp_sel_reg;
  logic [WIDTH-1:0] byp_data_reg;
  logic             ram_has_data;
  logic             vacate;
  logic             fill_ram;
  logic             fill_byp;

  assign empty = !out_valid_reg;

  // COUNT includes the head word, so the RAM holds words exactly when
  // COUNT exceeds the output-valid bit.
  assign ram_has_data = (count_reg != {{(CNT_W-1){1'b0}}, out_valid_reg});
  assign vacate       = !out_valid_reg || rd_acc;
  assign fill_ram     = vacate && ram_has_data;
  assign fill_byp     = vacate && !ram_has_data && wr_acc;
  assign ram_we       = wr_acc && !fill_byp;
  assign ram_re       = fill_ram;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      out_valid_reg <= 1'b0;
      byp_sel_reg   <= 1'b0;
      byp_data_reg  <= '0;
    end else begin
      out_valid_reg <= (out_valid_reg && !rd_acc) || fill_ram || fill_byp;
      if (fill_byp) begin
        byp_data_reg <= bus.DATA_WR;
        byp_sel_reg  <= 1'b1;
      end else if (fill_ram) begin
        byp_sel_reg  <= 1'b0;
      end
    end
  end

  assign bus.DATA_RD = byp_sel_reg ? byp_data_reg : ram_q;
`else
  assign empty       = (count_reg == '0);
  assign ram_we      = wr_acc;
  assign ram_re      = rd_acc;
  assign bus.DATA_RD = ram_q;
`endif

  fifo_sync_ram #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .ADDR_W(ADDR_W)
  ) u_ram (
    .clk  (CLK),
    .srst (RESET),
    .we   (ram_we),
    .waddr(wr_ptr_reg[ADDR_W-1:0]),
    .wdata(bus.DATA_WR),
    .re   (ram_re),
    .raddr(rd_ptr_reg[ADDR_W-1:0]),
    .rdata(ram_q)
  );

  always_ff @(posedge CLK) begin
    if (RESET) begin
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
      count_reg     <= '0;
      overflow_reg  <= 1'b0;
      underflow_reg <= 1'b0;
    end else begin
      if (ram_we) begin
        wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      end
      if (ram_re) begin
        rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      end
      count_reg     <= count_reg + CNT_W'(wr_acc) - CNT_W'(rd_acc);
      overflow_reg  <= bus.WR && full;
      underflow_reg <= bus.RD && empty;
    end
  end

  // Flags decode only registered state: no path from WR/RD to them.
  assign bus.FULL         = full;
  assign bus.EMPTY        = empty;
  assign bus.ALMOST_FULL  = (int'(count_reg) >= AF_LEVEL);
  assign bus.ALMOST_EMPTY = (int'(count_reg) <= AE_LEVEL);
  assign bus.COUNT        = count_reg;
  assign bus.OVERFLOW     = overflow_reg;
  assign bus.UNDERFLOW    = underflow_reg;

endmodule
